// File: rtl/if_fetch_predict.sv
// if_fetch_predict: IF-stage PC register with optional BTB and 2-bit predictor.
// Define IF_FETCH_BTB_EN to build the BTB; the default build fetches sequentially.
module if_fetch_predict #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        predict_o
);

    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic [31:0] pc_next;
    logic [31:0] pred_pc;
    logic        pred;

    assign pc_seq    = pc + 32'd4;
    assign imem_addr = pc;
    assign pc_o      = pc;
    assign instr_o   = imem_rdata;
    assign predict_o = pred;

`ifdef IF_FETCH_BTB_EN
    localparam int IDX = $clog2(BTB_ENTRIES);
    localparam int TW  = 30 - IDX;

    logic           valid [BTB_ENTRIES];
    logic [TW-1:0]  tag   [BTB_ENTRIES];
    logic [29:0]    tgt   [BTB_ENTRIES];
    logic [1:0]     ctr   [BTB_ENTRIES];

    logic [IDX-1:0] l_idx;
    logic [IDX-1:0] u_idx;
    logic [TW-1:0]  l_tag;
    logic [TW-1:0]  u_tag;
    logic           l_hit;
    logic           u_hit;
    logic [1:0]     unused_lo;

    assign l_idx     = pc[IDX+1:2];
    assign l_tag     = pc[31:IDX+2];
    assign u_idx     = upd_pc[IDX+1:2];
    assign u_tag     = upd_pc[31:IDX+2];
    assign l_hit     = valid[l_idx] && (tag[l_idx] == l_tag);
    assign u_hit     = valid[u_idx] && (tag[u_idx] == u_tag);
    assign pred      = l_hit && ctr[l_idx][1];
    assign pred_pc   = {tgt[l_idx], 2'b00};
    assign unused_lo = upd_pc[1:0] ^ upd_target[1:0];

    // Lookup reads the array before this edge, so same-index updates land next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid[i] <= 1'b0;
                ctr[i]   <= 2'b01;
            end
        end else if (upd_en) begin
            if (u_hit) begin
                if (upd_taken) begin
                    if (ctr[u_idx] != 2'b11)
                        ctr[u_idx] <= ctr[u_idx] + 2'd1;
                    tgt[u_idx] <= upd_target[31:2];
                end else if (ctr[u_idx] != 2'b00) begin
                    ctr[u_idx] <= ctr[u_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid[u_idx] <= 1'b1;
                tag[u_idx]   <= u_tag;
                tgt[u_idx]   <= upd_target[31:2];
                ctr[u_idx]   <= 2'b10;
            end
        end
    end
`else
    logic        unused_upd;
    logic [31:0] unused_cfg;

    assign pred       = 1'b0;
    assign pred_pc    = pc_seq;
    assign unused_upd = ^{upd_en, upd_pc, upd_target, upd_taken};
    assign unused_cfg = BTB_ENTRIES;
`endif

    logic [1:0] unused_rlo;
    assign unused_rlo = redirect_pc[1:0];

    always_comb begin
        if (redirect)
            pc_next = {redirect_pc[31:2], 2'b00};
        else if (stall)
            pc_next = pc;
        else if (pred)
            pc_next = pred_pc;
        else
            pc_next = pc_seq;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            pc <= RESET_PC;
        else
            pc <= pc_next;
    end

endmodule

// File: tb/tb_if_fetch_predict.sv
// tb_if_fetch_predict: vector table + scoreboard bench for if_fetch_predict.
// Expectations follow the build: IF_FETCH_BTB_EN selects the predicting model.
module tb_if_fetch_predict;

`ifdef IF_FETCH_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        upd_en = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_target = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        predict_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem(imem_addr);

    if_fetch_predict dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .upd_en     (upd_en),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .pc_o       (pc_o),
        .instr_o    (instr_o),
        .predict_o  (predict_o)
    );

    typedef struct {
        logic        rst;
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        ue;
        logic [31:0] upc;
        logic [31:0] utg;
        logic        ut;
        logic        chk;
        logic [31:0] epc;
        logic        ep;
    } vec_t;

    typedef struct {
        int          row;
        logic        chk;
        logic [31:0] epc;
        logic        ep;
    } exp_t;

    exp_t sb[$];
    vec_t tv[$];
    int   row = 0;

    function automatic logic [31:0] sel(input logic [31:0] a, input logic [31:0] b);
        return BTB ? a : b;
    endfunction

    function automatic vec_t mk(
        input logic rst, input logic st, input logic rd, input logic [31:0] rpc,
        input logic ue, input logic [31:0] upc, input logic [31:0] utg,
        input logic ut, input logic chk, input logic [31:0] epc, input logic ep);
        vec_t v;
        v.rst = rst; v.st = st; v.rd = rd; v.rpc = rpc;
        v.ue = ue; v.upc = upc; v.utg = utg; v.ut = ut;
        v.chk = chk; v.epc = epc; v.ep = ep;
        return v;
    endfunction

    task automatic step(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = v.rst; stall = v.st; redirect = v.rd; redirect_pc = v.rpc;
        upd_en = v.ue; upd_pc = v.upc; upd_target = v.utg; upd_taken = v.ut;
        e.row = row; e.chk = v.chk; e.epc = v.epc; e.ep = v.ep;
        sb.push_back(e);
        row++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                checks += 3;
                if (pc_o !== e.epc || imem_addr !== e.epc) begin
                    failures++;
                    $display("FAIL pc row%0d: pc_o=%h imem_addr=%h want %h",
                             e.row, pc_o, imem_addr, e.epc);
                end
                if (predict_o !== e.ep) begin
                    failures++;
                    $display("FAIL predict row%0d: got %b want %b",
                             e.row, predict_o, e.ep);
                end
                if (instr_o !== mem(e.epc)) begin
                    failures++;
                    $display("FAIL instr row%0d: got %h want %h",
                             e.row, instr_o, mem(e.epc));
                end
            end
        end
    end

    initial begin
        tv.push_back(mk(0,0,0,0,        0,0,0,0,               0,32'h0,0));
        tv.push_back(mk(1,0,0,0,        0,0,0,0,               1,32'h0,0));
        tv.push_back(mk(1,0,0,0,        1,32'h10,32'h40,1,     1,32'h4,0));
        tv.push_back(mk(1,0,0,0,        0,0,0,0,               1,32'h8,0));
        tv.push_back(mk(1,0,0,0,        0,0,0,0,               1,32'hC,0));
        tv.push_back(mk(1,0,0,0,        0,0,0,0,               1,32'h10,BTB));
        tv.push_back(mk(1,0,0,0,        0,0,0,0,               1,sel(32'h40,32'h14),0));
        tv.push_back(mk(1,0,0,0,        1,32'h10,32'h99C,0,    1,sel(32'h44,32'h18),0));
        tv.push_back(mk(1,0,0,0,        1,32'h10,32'h99C,0,    1,sel(32'h48,32'h1C),0));
        tv.push_back(mk(1,0,1,32'h10,   1,32'h10,32'h99C,0,    1,sel(32'h4C,32'h20),0));
        tv.push_back(mk(1,0,0,0,        1,32'h10,32'h40,1,     1,32'h10,0));
        tv.push_back(mk(1,0,1,32'h10,   0,0,0,0,               1,32'h14,0));
        tv.push_back(mk(1,0,0,0,        1,32'h10,32'h60,1,     1,32'h10,0));
        tv.push_back(mk(1,0,1,32'h10,   0,0,0,0,               1,32'h14,0));
        tv.push_back(mk(1,0,0,0,        0,0,0,0,               1,32'h10,BTB));
        tv.push_back(mk(1,1,1,32'h203,  0,0,0,0,               1,sel(32'h60,32'h14),0));
        tv.push_back(mk(1,1,0,0,        0,0,0,0,               1,32'h200,0));
        tv.push_back(mk(1,0,0,0,        0,0,0,0,               1,32'h200,0));
        tv.push_back(mk(1,0,0,0,        1,32'h50,32'h80,1,     1,32'h204,0));
        tv.push_back(mk(1,0,1,32'h10,   0,0,0,0,               1,32'h208,0));
        tv.push_back(mk(1,0,1,32'h50,   0,0,0,0,               1,32'h10,0));
        tv.push_back(mk(1,0,0,0,        0,0,0,0,               1,32'h50,BTB));
        tv.push_back(mk(1,0,1,32'h50,   1,32'h90,32'hA0,0,     1,sel(32'h80,32'h54),0));
        tv.push_back(mk(1,1,0,0,        0,0,0,0,               1,32'h50,BTB));
        tv.push_back(mk(1,0,0,0,        0,0,0,0,               1,32'h50,BTB));
        tv.push_back(mk(1,0,1,32'hFFFF_FFFC, 0,0,0,0,          1,sel(32'h80,32'h54),0));

        foreach (tv[i]) step(tv[i]);

        // Wrap-around, then reset landing on a pending redirect and update.
        step(mk(1,0,0,0,           0,0,0,0,             1,32'hFFFF_FFFC,0));
        step(mk(0,0,1,32'h300,     1,32'h0,32'h100,1,   1,32'h0,0));
        step(mk(1,0,0,0,           0,0,0,0,             1,32'h0,0));
        step(mk(1,0,1,32'h50,      0,0,0,0,             1,32'h4,0));
        step(mk(1,0,0,0,           0,0,0,0,             1,32'h50,0));
        step(mk(1,0,0,0,           0,0,0,0,             1,32'h54,0));

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_predict.md
IF_FETCH_PREDICT -- requirements
Module: if_fetch_predict

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 SHALL have parameter BTB_ENTRIES, default 16, number of BTB entries (power of 2, 2..64).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port stall  input  1  hold the PC (load-use or IF/ID hold).
REQ-006 SHALL have port redirect  input  1  EX-stage mispredict or jump correction.
REQ-007 SHALL have port redirect_pc  input  32  corrected fetch address.
REQ-008 SHALL have port upd_en  input  1  resolved branch/jump update from EX.
REQ-009 SHALL have port upd_pc  input  32  PC of the resolved instruction.
REQ-010 SHALL have port upd_target  input  32  resolved target address.
REQ-011 SHALL have port upd_taken  input  1  resolved direction.
REQ-012 SHALL have port imem_addr  output  32  instruction memory address (asynchronous-read memory).
REQ-013 SHALL have port imem_rdata  input  32  instruction word returned for imem_addr.
REQ-014 SHALL have port pc_o  output  32  current fetch PC, to the IF/ID register.
REQ-015 SHALL have port instr_o  output  32  fetched instruction, to the IF/ID register.
REQ-016 SHALL have port predict_o  output  1  predicted-taken flag, to the IF/ID register.

Function
REQ-017 SHALL hold a 32-bit PC register; imem_addr = pc_o = PC (combinational), instr_o = imem_rdata.
REQ-018 SHALL define IDX = log2(BTB_ENTRIES); index = PC[IDX+1:2]; tag = PC[31:IDX+2].
REQ-019 SHALL hold per entry: valid (1), tag, target (32), 2-bit saturating counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-020 SHALL assert predict_o combinationally when entry[index] is valid, its tag matches and counter[1]=1; else 0.
REQ-021 SHALL select the next PC with this priority: redirect -> {redirect_pc[31:2],2'b00}; else stall -> PC unchanged; else predict_o -> {entry target[31:2],2'b00}; else PC+4.
REQ-022 SHALL wrap PC+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 SHALL override stall with redirect when both are asserted in the same cycle.
REQ-024 SHALL perform BTB updates on upd_en independent of stall and redirect.
REQ-025 On upd_en with a valid tag match at upd_pc's index: SHALL increment the counter (saturating at 11) if upd_taken, else decrement it (saturating at 00); SHALL write upd_target when upd_taken.
REQ-026 On upd_en with a miss and upd_taken=1: SHALL allocate the entry (valid=1, tag, target=upd_target, counter=10), replacing any previous occupant.
REQ-027 On upd_en with a miss and upd_taken=0: SHALL leave the BTB unchanged.
REQ-028 SHALL perform lookup and update to the same index in the same cycle read-before-write: the lookup uses the pre-update entry.
REQ-029 SHALL keep predict_o and the next-PC selection a function of the current PC and BTB state only; updates take effect the following cycle.

Reset
REQ-030 With rst_n=0 at a rising edge: SHALL set PC=RESET_PC, clear every valid bit and set every counter to 01; this takes priority over stall, redirect and upd_en.
REQ-031 After reset: SHALL drive pc_o=imem_addr=RESET_PC and predict_o=0, with instr_o following imem_rdata.
REQ-032 Reset asserted mid-operation SHALL discard any in-flight update in that cycle.

Configuration
REQ-033 SHALL compile the BTB and counters only when macro IF_FETCH_BTB_EN is defined.
REQ-034 Without IF_FETCH_BTB_EN: SHALL tie predict_o=0, ignore upd_* and use next PC = redirect ? redirect_pc : stall ? PC : PC+4.

Verification
REQ-035 Reset, then 3 free-run cycles with no stall, redirect or update -> pc_o sequence 0x0, 0x4, 0x8, 0xC; predict_o=0 throughout.
REQ-036 upd_en with upd_pc=0x10, upd_target=0x40, upd_taken=1; then PC reaches 0x10 -> predict_o=1 and the next pc_o=0x40.
REQ-037 Two not-taken updates for 0x10 after allocation (10->01->00) -> at PC 0x10, predict_o=0 and next pc_o=0x14; further not-taken updates leave the counter at 00.
REQ-038 stall=1 and redirect=1 with redirect_pc=0x203 in the same cycle -> next pc_o=0x200.
REQ-039 Two upd_pc values with the same index but different tags, 0x10 then 0x50 (16 entries), both taken -> 0x50 replaces 0x10; PC 0x10 -> predict_o=0.
REQ-040 PC=0xFFFF_FFFC with no prediction -> next pc_o=0x0; with IF_FETCH_BTB_EN undefined, REQ-036 stimulus -> predict_o stays 0.
